load_bias_mbank: RTL and testbench

//  Generalised bias loader. On I_ap_start it fetches I_len beats from DDR over an AXI4 read master.

---
 rtl/load_bias_mbank_pkg.sv | 18 +
 rtl/load_bias_mbank_spram.sv | 22 ++
 rtl/load_bias_mbank.sv | 148 ++++++++++++++
 tb/tb_load_bias_mbank.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/load_bias_mbank_pkg.sv
// Shared definitions for the bias loader: FSM encoding, AXI4 burst-length width
// and the bytes-per-beat helper.
package load_bias_mbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int AXI_LEN_W = 8;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/load_bias_mbank_spram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module load_bias_mbank_spram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/load_bias_mbank.sv
// Bias loader: fetches I_len beats over AXI4 in bursts of up to C_MAX_BURST and
// stripes them round-robin over C_BANK_NUM banks read back as one wide word.
module load_bias_mbank
  import load_bias_mbank_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_BANK_NUM         = 4,
  parameter int C_LEN_WIDTH        = 16,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                                     I_clk,
  input  logic                                     I_rst_n,
  input  logic                                     I_ap_start,
  output logic                                     O_ap_done,
  output logic                                     O_ap_idle,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]            I_base_addr,
  input  logic [C_LEN_WIDTH-1:0]                   I_len,
  output logic                                     O_maxi_arvalid,
  input  logic                                     I_maxi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            O_maxi_araddr,
  output logic [AXI_LEN_W-1:0]                     O_maxi_arlen,
  output logic                                     O_maxi_rready,
  input  logic                                     I_maxi_rvalid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]            I_maxi_rdata,
  input  logic                                     I_maxi_rlast,
  input  logic [C_RAM_ADDR_WIDTH-1:0]              I_raddr,
  output logic [C_BANK_NUM*C_M_AXI_DATA_WIDTH-1:0] O_rdata
);

  localparam int BPB      = bytes_per_beat(C_M_AXI_DATA_WIDTH);
  localparam int BANK_LOG = $clog2(C_BANK_NUM);
  localparam int BSEL_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
  localparam logic [C_LEN_WIDTH-1:0] MAXB = C_LEN_WIDTH'(C_MAX_BURST);
  localparam logic [C_LEN_WIDTH-1:0] ONE  = C_LEN_WIDTH'(1);

  state_t                  state;
  logic [C_LEN_WIDTH-1:0]  remaining;
  logic [C_LEN_WIDTH-1:0]  beat_idx;
  logic [C_LEN_WIDTH-1:0]  cur_burst;
  logic                    ar_fire;
  logic                    wr_fire;

  function automatic logic [C_LEN_WIDTH-1:0] clip(input logic [C_LEN_WIDTH-1:0] n);
    return (n > MAXB) ? MAXB : n;
  endfunction

  assign ar_fire   = O_maxi_arvalid & I_maxi_arready;
  assign wr_fire   = I_maxi_rvalid & O_maxi_rready;
  // arlen is held for the whole burst, so it doubles as the burst size register
  assign cur_burst = C_LEN_WIDTH'(O_maxi_arlen) + ONE;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state          <= ST_IDLE;
      O_ap_done      <= 1'b0;
      O_ap_idle      <= 1'b1;
      O_maxi_arvalid <= 1'b0;
      O_maxi_rready  <= 1'b0;
      O_maxi_araddr  <= '0;
      O_maxi_arlen   <= '0;
      remaining      <= '0;
      beat_idx       <= '0;
    end else begin
      // done trails the DONE state by one cycle, coinciding with the return to idle
      O_ap_done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (I_ap_start) begin
            remaining <= I_len;
            beat_idx  <= '0;
            O_ap_idle <= 1'b0;
            if (I_len == '0) begin
              state <= ST_DONE;
            end else begin
              state          <= ST_AR;
              O_maxi_arvalid <= 1'b1;
              O_maxi_araddr  <= I_base_addr;
              O_maxi_arlen   <= AXI_LEN_W'(clip(I_len) - ONE);
            end
          end
        end
        ST_AR: begin
          if (ar_fire) begin
            state          <= ST_DATA;
            O_maxi_arvalid <= 1'b0;
            O_maxi_rready  <= 1'b1;
            O_maxi_araddr  <= O_maxi_araddr +
                              C_M_AXI_ADDR_WIDTH'(cur_burst) * C_M_AXI_ADDR_WIDTH'(BPB);
            remaining      <= remaining - cur_burst;
          end
        end
        ST_DATA: begin
          if (wr_fire) begin
            beat_idx <= beat_idx + ONE;
            if (I_maxi_rlast) begin
              O_maxi_rready <= 1'b0;
              if (remaining == '0) begin
                state <= ST_DONE;
              end else begin
                state          <= ST_AR;
                O_maxi_arvalid <= 1'b1;
                O_maxi_arlen   <= AXI_LEN_W'(clip(remaining) - ONE);
              end
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          O_ap_idle <= 1'b1;
        end
      endcase
    end
  end

  logic [BSEL_W-1:0]           bank_sel;
  logic [C_RAM_ADDR_WIDTH-1:0] wr_addr;
  logic [C_BANK_NUM-1:0]       bank_we;
  logic [C_BANK_NUM-1:0][C_M_AXI_DATA_WIDTH-1:0] bank_rdata;

  // word index past the bank-select bits wraps naturally at the bank depth
  assign wr_addr = beat_idx[BANK_LOG +: C_RAM_ADDR_WIDTH];

  if (BANK_LOG > 0) begin : g_sel
    assign bank_sel = beat_idx[BSEL_W-1:0];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  for (genvar b = 0; b < C_BANK_NUM; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (bank_sel == BSEL_W'(b));
    load_bias_mbank_spram #(
      .DATA_W (C_M_AXI_DATA_WIDTH),
      .ADDR_W (C_RAM_ADDR_WIDTH)
    ) u_ram (
      .clk   (I_clk),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (I_maxi_rdata),
      .raddr (I_raddr),
      .rdata (bank_rdata[b])
    );
  end

  assign O_rdata = bank_rdata;

endmodule

// File: tb/tb_load_bias_mbank.sv
// Directed/randomized bench for load_bias_mbank: an AXI read slave plus a striping
// reference model, run against a 4-bank and a 1-bank/1-beat-burst instance.
module tb_load_bias_mbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, arready, rvalid, rlast, sel;
  logic [15:0]  len;
  logic [31:0]  base;
  logic [127:0] rdata;
  logic [9:0]   raddr;

  logic         done0, idle0, arvalid0, rready0;
  logic [31:0]  araddr0;
  logic [7:0]   arlen0;
  logic [511:0] ordata0;
  logic         done1, idle1, arvalid1, rready1;
  logic [31:0]  araddr1;
  logic [7:0]   arlen1;
  logic [127:0] ordata1;

  logic         done_o, idle_o, arvalid_o, rready_o;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;

  assign done_o    = sel ? done1    : done0;
  assign idle_o    = sel ? idle1    : idle0;
  assign arvalid_o = sel ? arvalid1 : arvalid0;
  assign rready_o  = sel ? rready1  : rready0;
  assign araddr_o  = sel ? araddr1  : araddr0;
  assign arlen_o   = sel ? arlen1   : arlen0;

  load_bias_mbank dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_ap_start(start & ~sel), .O_ap_done(done0),
    .O_ap_idle(idle0), .I_base_addr(base), .I_len(len), .O_maxi_arvalid(arvalid0),
    .I_maxi_arready(arready), .O_maxi_araddr(araddr0), .O_maxi_arlen(arlen0),
    .O_maxi_rready(rready0), .I_maxi_rvalid(rvalid), .I_maxi_rdata(rdata),
    .I_maxi_rlast(rlast), .I_raddr(raddr), .O_rdata(ordata0)
  );

  load_bias_mbank #(.C_BANK_NUM(1), .C_MAX_BURST(1)) dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_ap_start(start & sel), .O_ap_done(done1),
    .O_ap_idle(idle1), .I_base_addr(base), .I_len(len), .O_maxi_arvalid(arvalid1),
    .I_maxi_arready(arready), .O_maxi_araddr(araddr1), .O_maxi_arlen(arlen1),
    .O_maxi_rready(rready1), .I_maxi_rvalid(rvalid), .I_maxi_rdata(rdata),
    .I_maxi_rlast(rlast), .I_raddr(raddr), .O_rdata(ordata1)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] mdl  [0:3][0:1023];
  bit           mvld [0:3][0:1023];
  logic [127:0] last_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arvalid"}, arvalid0, 0);
    chk({tag, "_rready"},  rready0,  0);
    chk({tag, "_done"},    done0,    0);
    chk({tag, "_idle"},    idle0,    1);
    chk({tag, "_araddr"},  araddr0,  0);
    chk({tag, "_arlen"},   arlen0,   0);
  endtask

  // Acts as the AXI slave for one load and checks AR sequence, beat count and done timing.
  task automatic run_load(input bit s, input int n, input logic [31:0] b,
                          input bit stall, input bit poke, input int abort_at);
    int mb, rem, beats, bb, cb, ar_n, done_n, done_cyc, last_cyc, cyc;
    logic [31:0] nxt_addr, h_addr;
    logic [7:0]  h_len;
    bit hold, poked;
    mb = s ? 1 : 16;
    rem = n; nxt_addr = b; beats = 0; bb = 0; cb = 0; ar_n = 0;
    done_n = 0; done_cyc = -1; last_cyc = 0; cyc = 0; hold = 0; poked = 0;
    @(negedge clk);
    sel = s; len = 16'(n); base = b; start = 1'b1;
    while (cyc < 3000 && !(done_n > 0 && cyc >= done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      if (done_o) begin done_n++; done_cyc = cyc; end
      if (arvalid_o) begin
        if (hold) begin
          chk("ar_addr_stable", araddr_o, h_addr);
          chk("ar_len_stable", arlen_o, h_len);
        end else begin
          hold = 1; h_addr = araddr_o; h_len = arlen_o; ar_n++;
          cb = (rem < mb) ? rem : mb;
          chk("ar_addr", araddr_o, nxt_addr);
          chk("ar_len", arlen_o, 128'(cb - 1));
        end
        arready = !stall || ($urandom_range(0, 5) == 0);
        if (arready) begin hold = 0; rem -= cb; nxt_addr += 32'(cb * 16); bb = 0; end
      end
      if (rready_o) begin
        rvalid = !stall || ($urandom_range(0, 3) == 0);
        if (rvalid) begin
          rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          rlast = (bb == cb - 1);
          if (!s) begin
            mdl[beats % 4][(beats / 4) % 1024] = rdata;
            mvld[beats % 4][(beats / 4) % 1024] = 1'b1;
          end
          last_data = rdata;
          beats++; bb++; last_cyc = cyc;
          if (abort_at > 0 && beats == abort_at) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 chk_reset("abort");
            @(negedge clk);
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rst_n = 1'b1;
            return;
          end
        end
        if (poke && !poked && beats >= 2) begin
          start = 1'b1; len = 16'd99; base = 32'hdead0000; poked = 1;
        end
      end
    end
    chk("ar_count", ar_n, (n + mb - 1) / mb);
    chk("beat_count", beats, n);
    chk("done_count", done_n, 1);
    chk("done_latency", done_cyc, (n == 0) ? 2 : last_cyc + 2);
    chk("idle_after", idle_o, 1);
  endtask

  task automatic readback(input int words);
    for (int a = 0; a < words; a++) begin
      @(negedge clk);
      raddr = 10'(a);
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (mvld[k][a]) chk($sformatf("rd_b%0d_a%0d", k, a), ordata0[k*128 +: 128], mdl[k][a]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    sel = 1'b0; len = '0; base = '0; rdata = '0; raddr = '0; last_data = '0;
    #12 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    run_load(0, 8, 32'h1000, 0, 0, 0);
    readback(2);
    run_load(0, 40, 32'h1000, 0, 0, 0);
    readback(10);
    run_load(0, 0, 32'h1000, 0, 0, 0);
    run_load(0, 37, 32'h2000, 1, 0, 0);
    readback(10);
    run_load(0, 40, 32'h3000, 0, 0, 20);
    run_load(0, 8, 32'h4000, 0, 0, 0);
    readback(2);
    run_load(0, 24, 32'h5000, 1, 1, 0);
    readback(6);

    run_load(1, 3, 32'h6000, 0, 1, 0);
    @(negedge clk) raddr = 10'd2;
    @(negedge clk) chk("bank1_last_word", ordata1, last_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
